// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants and counter width for the scanout path
package vga_pkg;

    localparam int CNT_W = 12;

    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
    } vga_timing_t;

    localparam vga_timing_t TIMING_800X600 = '{
        h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23
    };

    localparam vga_timing_t TIMING_640X480 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33
    };

endpackage

// File: rtl/vga_timing_cnt.sv
// vga_timing_cnt: h/v raster counters with active and sync region decode
module vga_timing_cnt
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_act,
    output logic             v_act,
    output logic             h_sync,
    output logic             v_sync
);

    localparam logic [CNT_W-1:0] H_A   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_S0  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_S1  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_A   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_S0  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_S1  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic h_last, v_last;

    assign h_last = h_cnt == H_END;
    assign v_last = v_cnt == V_END;

    // Disabling parks the raster at the origin so re-enable starts a fresh frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (!enable || h_last) ? '0 : h_cnt + CNT_W'(1);
            v_cnt <= !enable ? '0 : h_last ? (v_last ? '0 : v_cnt + CNT_W'(1)) : v_cnt;
        end
    end

    assign h_act  = h_cnt < H_A;
    assign v_act  = v_cnt < V_A;
    assign h_sync = h_cnt >= H_S0 && h_cnt < H_S1;
    assign v_sync = v_cnt >= V_S0 && v_cnt < V_S1;

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: streams upstream RGB565 pixels onto registered VGA timing with underflow tracking
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(TIMING_800X600.h_active),
    parameter int H_FP     = int'(TIMING_800X600.h_fp),
    parameter int H_SYNC   = int'(TIMING_800X600.h_sync),
    parameter int H_BP     = int'(TIMING_800X600.h_bp),
    parameter int V_ACTIVE = int'(TIMING_800X600.v_active),
    parameter int V_FP     = int'(TIMING_800X600.v_fp),
    parameter int V_SYNC   = int'(TIMING_800X600.v_sync),
    parameter int V_BP     = int'(TIMING_800X600.v_bp),
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    output logic        pix_ready_o,
    output logic [9:0]  req_x_o,
    output logic [9:0]  req_y_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [15:0] rgb_o,
    output logic        frame_start_o,
    output logic        underflow_o,
    input  logic        underflow_clr_i,
    output logic [15:0] underflow_cnt_o
);

    localparam logic             HS_ON  = HS_POL != 0;
    localparam logic             VS_ON  = VS_POL != 0;
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_act, v_act, h_sync, v_sync, xfer, under;

    vga_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .enable (enable_i),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_act  (h_act),
        .v_act  (v_act),
        .h_sync (h_sync),
        .v_sync (v_sync)
    );

    // Reset gates ready directly so nothing is consumed while rst_ni is held low.
    assign pix_ready_o = rst_ni && enable_i && h_act && v_act;
    assign xfer        = pix_ready_o && pix_valid_i;
    assign under       = pix_ready_o && !pix_valid_i;
    assign req_x_o     = h_act ? 10'(h_cnt) : '0;
    assign req_y_o     = v_cnt < V_LAST ? 10'(v_cnt + CNT_W'(1)) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_o         <= !HS_ON;
            vsync_o         <= !VS_ON;
            de_o            <= 1'b0;
            rgb_o           <= '0;
            frame_start_o   <= 1'b0;
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else begin
            hsync_o         <= (enable_i && h_sync) ? HS_ON : !HS_ON;
            vsync_o         <= (enable_i && v_sync) ? VS_ON : !VS_ON;
            de_o            <= pix_ready_o;
            rgb_o           <= xfer ? pix_data_i : '0;
            frame_start_o   <= pix_ready_o && h_cnt == '0 && v_cnt == '0;
            underflow_o     <= under || (underflow_o && !underflow_clr_i);
            underflow_cnt_o <= under ? (underflow_clr_i ? 16'd1 :
                                        underflow_cnt_o + {15'd0, underflow_cnt_o != 16'hFFFF}) :
                               underflow_clr_i ? '0 : underflow_cnt_o;
        end
    end

endmodule
